shift_add_mul: RTL and testbench

Sequential unsigned multiplier for the ALU arithmetic group. It iterates shift-and-add over WIDTH cycles. Every partial-product addition goes through the existing combinational adder instance: this block drives the adder's a/b operands and consumes its o result each cycle. It provides a start/busy/done handshake to the ALU control and returns a full 2*WIDTH-bit product as hi/lo halves.

---
 rtl/shift_add_mul.sv | 142 ++++++++++++++
 tb/tb_shift_add_mul.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mul.sv
// Sequential unsigned shift-and-add multiplier: WIDTH iterations through a shared
// combinational adder, start/busy/done handshake, registered 2*WIDTH-bit product.

module comb_adder #(
  parameter int unsigned WIDTH = 20
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] o
);

  assign o = a + b;

endmodule

module shift_add_mul #(
  parameter int unsigned WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
  logic [WIDTH-1:0] prod_lo_q, prod_lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] adder_o;
  logic [WIDTH-1:0] part_sum;
  logic             part_carry;

  comb_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a (acc_hi_q),
    .b (mcand_q),
    .o (adder_o)
  );

  // The adder has no carry-out; an unsigned wrap shows up as a result below mcand.
  assign part_sum   = acc_lo_q[0] ? adder_o : acc_hi_q;
  assign part_carry = acc_lo_q[0] && (adder_o < mcand_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    prod_hi_d = prod_hi_q;
    prod_lo_d = prod_lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d  = a;
          acc_lo_d = b;
          acc_hi_d = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_RUN;
        end
      end

      ST_RUN: begin
        acc_hi_d = {part_carry, part_sum[WIDTH-1:1]};
        acc_lo_d = {part_sum[0], acc_lo_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == LAST_ITER) begin
          state_d = ST_FIN;
        end
      end

      ST_FIN: begin
        prod_hi_d = acc_hi_q;
        prod_lo_d = acc_lo_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      prod_hi_q <= prod_hi_d;
      prod_lo_q <= prod_lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign prod_hi = prod_hi_q;
  assign prod_lo = prod_lo_q;

endmodule

// File: tb/tb_shift_add_mul.sv
// Directed bench for shift_add_mul: reset, products, latency, handshake corners.

module tb_shift_add_mul;

  localparam int unsigned W = 20;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] prod_lo;
  logic [W-1:0] prod_hi;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  shift_add_mul #(
    .WIDTH (W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .prod_lo (prod_lo),
    .prod_hi (prod_hi)
  );

  // Starts one operation from #1 after an edge; returns edges until done (or -1).
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, output int lat);
    a = ta;
    b = tb_v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({busy, done, prod_hi, prod_lo} !== '0)
      $display("FAIL reset_held got busy=%0b done=%0b hi=%0h lo=%0h exp all 0",
               busy, done, prod_hi, prod_lo);
    else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({busy, done, prod_hi, prod_lo} !== '0)
      $display("FAIL reset_release got busy=%0b done=%0b hi=%0h lo=%0h exp all 0",
               busy, done, prod_hi, prod_lo);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int lat = -1;
    int bad_busy = 0;
    a = 20'd3;
    b = 20'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) begin
        @(posedge clk); #1;
      end
      if (done) begin
        lat = n - 1;
        break;
      end
      if (busy !== 1'b1) bad_busy++;
    end
    total_cnt++;
    if (lat !== 21) $display("FAIL basic_latency got=%0d exp=21", lat);
    else pass_cnt++;
    total_cnt++;
    if (bad_busy !== 0) $display("FAIL basic_busy_high low_cycles=%0d exp=0", bad_busy);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL basic_busy_at_done got=%0b exp=0", busy);
    else pass_cnt++;
    total_cnt++;
    if ({prod_hi, prod_lo} !== 40'h00000_0000F)
      $display("FAIL basic_product got=%0h_%0h exp=00000_0000f", prod_hi, prod_lo);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (done !== 1'b0) $display("FAIL basic_done_pulse got=%0b exp=0", done);
    else pass_cnt++;
    total_cnt++;
    if (prod_lo !== 20'h0000F) $display("FAIL basic_hold got=%0h exp=f", prod_lo);
    else pass_cnt++;
  endtask

  task automatic test_max();
    int lat;
    run_op(20'hFFFFF, 20'hFFFFF, lat);
    total_cnt++;
    if (lat !== 21) $display("FAIL max_latency got=%0d exp=21", lat);
    else pass_cnt++;
    total_cnt++;
    if ({prod_hi, prod_lo} !== 40'hFFFFE_00001)
      $display("FAIL max_product got=%0h_%0h exp=ffffe_00001", prod_hi, prod_lo);
    else pass_cnt++;
  endtask

  task automatic test_zero_carry();
    int lat;
    run_op(20'h00000, 20'h12345, lat);
    total_cnt++;
    if (lat !== 21) $display("FAIL zero_latency got=%0d exp=21", lat);
    else pass_cnt++;
    total_cnt++;
    if ({prod_hi, prod_lo} !== 40'h0)
      $display("FAIL zero_product got=%0h_%0h exp=0_0", prod_hi, prod_lo);
    else pass_cnt++;
    run_op(20'h80000, 20'h00002, lat);
    total_cnt++;
    if ({prod_hi, prod_lo} !== 40'h00001_00000)
      $display("FAIL carry_product got=%0h_%0h exp=00001_00000", prod_hi, prod_lo);
    else pass_cnt++;
  endtask

  task automatic test_start_while_busy();
    int ndone = 0;
    int lat = -1;
    int leaks = 0;
    logic [2*W-1:0] got = '0;
    a = 20'd7;
    b = 20'd9;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 50; n++) begin
      @(posedge clk); #1;
      if (n == 4) begin
        start = 1'b1;
        a = 20'd2;
        b = 20'd2;
      end
      if (n == 5) start = 1'b0;
      if (done) begin
        ndone++;
        if (lat < 0) lat = n;
        got = {prod_hi, prod_lo};
      end else if (ndone == 0 && {prod_hi, prod_lo} !== 40'h00001_00000) leaks++;
    end
    total_cnt++;
    if (ndone !== 1) $display("FAIL busy_start_dones got=%0d exp=1", ndone);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 21) $display("FAIL busy_start_latency got=%0d exp=21", lat);
    else pass_cnt++;
    total_cnt++;
    if (got !== 40'h3F) $display("FAIL busy_start_product got=%0h exp=3f", got);
    else pass_cnt++;
    total_cnt++;
    if (leaks !== 0) $display("FAIL busy_prod_hold changed_cycles=%0d exp=0", leaks);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(20'd5, 20'd5, lat);
    total_cnt++;
    if (prod_lo !== 20'h19) $display("FAIL b2b_first got=%0h exp=19", prod_lo);
    else pass_cnt++;
    run_op(20'd4, 20'd4, lat);
    total_cnt++;
    if (lat !== 21) $display("FAIL b2b_latency got=%0d exp=21", lat);
    else pass_cnt++;
    total_cnt++;
    if ({prod_hi, prod_lo} !== 40'h10)
      $display("FAIL b2b_product got=%0h_%0h exp=0_10", prod_hi, prod_lo);
    else pass_cnt++;
  endtask

  task automatic test_held_start();
    int first = -1;
    int gap = -1;
    a = 20'd3;
    b = 20'd3;
    start = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk); #1;
      if (done) begin
        if (first < 0) first = n;
        else begin
          gap = n - first;
          break;
        end
      end
    end
    start = 1'b0;
    total_cnt++;
    if (gap !== 22) $display("FAIL held_start_gap got=%0d exp=22", gap);
    else pass_cnt++;
    total_cnt++;
    if (prod_lo !== 20'd9) $display("FAIL held_start_product got=%0h exp=9", prod_lo);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL held_start_idle got busy=%0b exp=0", busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat;
    int stray = 0;
    a = 20'h12345;
    b = 20'h00100;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy, done, prod_hi, prod_lo} !== '0)
      $display("FAIL async_reset got busy=%0b done=%0b hi=%0h lo=%0h exp all 0",
               busy, done, prod_hi, prod_lo);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (done || busy) stray++;
    end
    total_cnt++;
    if (stray !== 0) $display("FAIL reset_no_done active_cycles=%0d exp=0", stray);
    else pass_cnt++;
    run_op(20'd6, 20'd7, lat);
    total_cnt++;
    if ({prod_hi, prod_lo} !== 40'h2A || lat !== 21)
      $display("FAIL post_reset_op got=%0h_%0h lat=%0d exp=0_2a lat=21", prod_hi, prod_lo, lat);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int lat;
    logic [31:0] seed = 32'h1357_9BDF;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [2*W-1:0] expv;
    for (int i = 0; i < 10; i++) begin
      seed = seed * 32'd1664525 + 32'd1013904223;
      ra = seed[31:12];
      seed = seed * 32'd1664525 + 32'd1013904223;
      rb = seed[31:12];
      expv = (2*W)'(ra) * (2*W)'(rb);
      run_op(ra, rb, lat);
      total_cnt++;
      if ({prod_hi, prod_lo} !== expv || lat !== 21)
        $display("FAIL random_%0d a=%0h b=%0h got=%0h lat=%0d exp=%0h lat=21",
                 i, ra, rb, {prod_hi, prod_lo}, lat, expv);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero_carry();
    test_start_while_busy();
    test_back_to_back();
    test_held_start();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
